// File: rtl/ex_fw_ctrl.sv
// ex_fw_ctrl: issue-time hazard detection and EX bypass-bus control for the ID->EX->MEM->WB pipeline.
// Define FWD_WB_BYPASS_EN to forward from WB; without it, MEM-slot dependencies stall until the register file has the value.
module ex_fw_ctrl #(
    parameter int MULTI_LAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_rd_we_i,
    input  logic       id_is_load_i,
    input  logic       id_is_multi_i,
    input  logic       flush_i,
    output logic       stall_o,
    output logic       ex_hold_o,
    output logic [1:0] fw_stage_o,
    output logic [1:0] fw_regs_o
);
    localparam int CNT_W = $clog2(MULTI_LAT);
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] RS_NONE = 2'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } slot_t;

    // The register file is write-through, so an instruction in WB never
    // creates a hazard; only the EX and MEM occupants are tracked, and the
    // MEM slot keeps just "is a producer" plus its destination.
    slot_t            ex_reg;
    logic             mem_prod_reg;
    logic [4:0]       mem_rd_reg;
    logic [CNT_W-1:0] busy_cnt_reg;

    logic       busy;
    logic       ex_producer;
    logic       conflict;
    logic       issue;
    logic [1:0] op_block;
    logic [1:0] op_need [2];
    logic [4:0] op_rs   [2];
    logic       op_use  [2];
    logic [1:0] fw_stage_next;
    logic [1:0] fw_regs_next;

    assign busy        = (busy_cnt_reg != '0);
    assign ex_producer = ex_reg.valid & ex_reg.we & (ex_reg.rd != 5'd0);

    assign op_rs[0]  = id_rs1_i;
    assign op_rs[1]  = id_rs2_i;
    assign op_use[0] = id_use_rs1_i;
    assign op_use[1] = id_use_rs2_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic ex_hit;
            logic mem_hit;
            assign ex_hit  = op_use[gi] & ex_producer & (ex_reg.rd == op_rs[gi]);
            assign mem_hit = op_use[gi] & mem_prod_reg & (mem_rd_reg == op_rs[gi]);
`ifdef FWD_WB_BYPASS_EN
            localparam logic [1:0] ST_WB = 2'd2;
            assign op_block[gi] = ex_hit & ex_reg.load;
            assign op_need[gi]  = ex_hit ? ST_MEM : (mem_hit ? ST_WB : ST_NONE);
`else
            assign op_block[gi] = (ex_hit & ex_reg.load) | (~ex_hit & mem_hit);
            assign op_need[gi]  = ex_hit ? ST_MEM : ST_NONE;
`endif
        end
    endgenerate

    // Only one bypass bus: two operands wanting different stages cannot both be served.
    assign conflict = (op_need[0] != ST_NONE) & (op_need[1] != ST_NONE) &
                      (op_need[0] != op_need[1]);

    assign stall_o   = id_valid_i & ((|op_block) | conflict | busy);
    assign issue     = id_valid_i & ~stall_o & ~flush_i;
    assign ex_hold_o = busy;

    assign fw_stage_next = (op_need[0] != ST_NONE) ? op_need[0] : op_need[1];
    assign fw_regs_next  = {op_need[1] != ST_NONE, op_need[0] != ST_NONE};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_reg       <= '0;
            mem_prod_reg <= 1'b0;
            mem_rd_reg   <= 5'd0;
            busy_cnt_reg <= '0;
            fw_stage_o   <= ST_NONE;
            fw_regs_o    <= RS_NONE;
        end else if (flush_i) begin
            ex_reg       <= '0;
            // A multi-cycle op aborted mid-flight never reaches MEM.
            mem_prod_reg <= ex_producer & ~busy;
            mem_rd_reg   <= ex_reg.rd;
            busy_cnt_reg <= '0;
            fw_stage_o   <= ST_NONE;
            fw_regs_o    <= RS_NONE;
        end else if (busy) begin
            mem_prod_reg <= 1'b0;
            busy_cnt_reg <= busy_cnt_reg - CNT_W'(1);
        end else begin
            mem_prod_reg <= ex_producer;
            mem_rd_reg   <= ex_reg.rd;
            if (issue) begin
                ex_reg       <= '{valid: 1'b1, rd: id_rd_i, we: id_rd_we_i, load: id_is_load_i};
                busy_cnt_reg <= id_is_multi_i ? CNT_W'(MULTI_LAT - 1) : '0;
                fw_stage_o   <= fw_stage_next;
                fw_regs_o    <= fw_regs_next;
            end else begin
                ex_reg     <= '0;
                fw_stage_o <= ST_NONE;
                fw_regs_o  <= RS_NONE;
            end
        end
    end

endmodule
